tmr_vote_monitor: RTL
=====================

# tmr_vote_monitor

Registered bitwise majority voter that collapses a triplicated bus (lanes A/B/C) back to a single copy at the boundary between triplicated and non-triplicated logic. It reports voting-error statistics per lane. Per-lane disagreement counters are kept, and a lane is reported over a valid/ready handshake once its error count reaches a threshold, so supervisory logic can schedule scrubbing or reconfiguration. The block is the reading end of the triplication path: upstream triplicated buffers drive its three lanes, and downstream single-copy logic consumes its output.

## Interface
- WIDTH, 6, bit width of each lane and of the voted output
- CNT_W, 8, width of each per-lane error counter
- THRESH, 4, counter value (1..2^CNT_W-1) at which a lane is reported

- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_a / in_b / in_c  input  WIDTH  triplicated lane inputs
- in_valid  input  1  lanes carry a word this cycle
- clear  input  1  synchronous clear of all three counters
- out  output  WIDTH  voted word
- out_valid  output  1  out is valid
- err_a / err_b / err_c  output  1  one-cycle flag, lane disagreed with vote
- multi_err  output  1  one-cycle flag, two or more lanes disagreed in same word
- cnt_a / cnt_b / cnt_c  output  CNT_W  per-lane saturating error counts
- rpt_valid  output  1  report pending
- rpt_ready  input  1  consumer accepts report
- rpt_lane  output  2  reported lane: 0=A, 1=B, 2=C
- rpt_count  output  CNT_W  counter value latched when report raised

## Operation
- Vote: `v = (a&b)|(a&c)|(b&c)`, applied bitwise.
- Lane X errs when `in_X != v` on any bit.
- multi_err is set when at least two lanes err in the same word. The bitwise vote is still output in that case.
- When in_valid=0:
  - out holds its previous value.
  - out_valid, err_*, and multi_err are 0.
  - Counters do not change.
- Counters:
  - +1 on each err_X event.
  - Saturate at 2^CNT_W-1.
  - Never wrap.
- Counter update priority, per lane, highest first:
  - clear sets the counter to 0.
  - Report acceptance for that lane sets the counter to 0.
  - Otherwise the counter increments on err_X.
- FSM states are IDLE and REPORT.
- IDLE:
  - If any counter is at or above THRESH, latch rpt_lane by priority A > B > C.
  - Latch rpt_count from that counter.
  - Go to REPORT, with rpt_valid=1 from the next cycle.
- REPORT:
  - rpt_valid stays high.
  - rpt_lane and rpt_count are stable until handshake.
  - Handshake is `rpt_valid & rpt_ready`. On handshake, clear the reported lane's counter and return to IDLE.
  - Other lanes keep counting while in REPORT.
- clear while in REPORT:
  - Clears the counters.
  - Does not withdraw the pending report.
- After a handshake, the FSM spends at least one cycle in IDLE before the next report.

## Timing
- Reset values:
  - out=0, out_valid=0.
  - err_*=0, multi_err=0.
  - cnt_*=0.
  - rpt_valid=0, rpt_lane=0, rpt_count=0.
  - FSM in IDLE.
- Reset mid-REPORT drops rpt_valid immediately (asynchronously).
- Latency:
  - in_valid at edge N produces out, out_valid, err_*, multi_err, and the updated cnt_* at edge N+1.
  - Counter reaches THRESH at edge N+1, so rpt_valid rises at edge N+2.
- rpt_ready is sampled only while rpt_valid=1.
- rpt_ready asserted in the same cycle rpt_valid rises completes the handshake on that edge.
- Throughput is one word per cycle, with no backpressure on the vote path.

## Structure
- Package tmr_vote_pkg holds:
  - lane_t enum (LANE_A=0, LANE_B=1, LANE_C=2).
  - state_t enum (IDLE, REPORT).
- Sub-module majority_voter is a combinational bitwise 3-input majority of WIDTH bits.
  - It produces the vote plus the three disagree flags.
  - It is instantiated once.
- Counters and FSM live in the top module.

## Test plan
- Clean data: a=b=c=6'h2A with in_valid for 10 cycles → out=6'h2A one cycle later, err_*=0, cnt_*=0, rpt_valid never rises.
- Single-lane fault: b=6'h2B, a=c=6'h2A for 4 words (THRESH=4) → out=6'h2A, err_b pulses 4 times, cnt_b=4, rpt_valid rises 2 cycles after the 4th word with rpt_lane=1 and rpt_count=4.
- Multi-lane fault: a=6'h01, b=6'h02, c=6'h00 → out=6'h00, err_a=err_b=1, multi_err=1, cnt_a=cnt_b=1.
- Report priority: drive cnt_a and cnt_c to THRESH on the same word.
  - Expected: lane 0 is reported first.
  - After rpt_ready, cnt_a=0 and lane 2 is reported after one IDLE cycle.
- Saturation and clear, with CNT_W=2 and THRESH=3:
  - Hold rpt_ready=0 and inject 5 lane-C errors → cnt_c stays at 3.
  - Pulse clear → cnt_c=0, rpt_valid still 1.
  - clear and err_c in the same cycle → cnt_c=0.
- Reset mid-report: assert rst while rpt_valid=1 → all outputs return to reset values immediately; after rst deasserts, no report occurs until new errors reach THRESH.

Source files
------------

// File: rtl/tmr_vote_pkg.sv
// Shared types for the TMR vote monitor: lane identifiers and report FSM states.
package tmr_vote_pkg;

  typedef enum logic [1:0] {
    LANE_A = 2'd0,
    LANE_B = 2'd1,
    LANE_C = 2'd2
  } lane_t;

  typedef enum logic {
    IDLE   = 1'b0,
    REPORT = 1'b1
  } state_t;

endpackage

// File: rtl/majority_voter.sv
// Combinational bitwise 2-of-3 majority with per-lane disagreement flags.
module majority_voter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] vote,
  output logic             dis_a,
  output logic             dis_b,
  output logic             dis_c
);

  assign vote  = (a & b) | (a & c) | (b & c);
  assign dis_a = (a != vote);
  assign dis_b = (b != vote);
  assign dis_c = (c != vote);

endmodule

// File: rtl/tmr_vote_monitor.sv
// Registered TMR voter with per-lane saturating error counters and a
// valid/ready report channel that flags lanes whose count reaches THRESH.
module tmr_vote_monitor
  import tmr_vote_pkg::*;
#(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             err_a,
  output logic             err_b,
  output logic             err_c,
  output logic             multi_err,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [1:0]       rpt_lane,
  output logic [CNT_W-1:0] rpt_count
);

  localparam logic [CNT_W-1:0] ThreshCnt = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  logic [WIDTH-1:0]            vote;
  logic [2:0]                  dis;
  logic [2:0][CNT_W-1:0]       cnt_q, cnt_d;
  state_t                      state_q, state_d;
  lane_t                       lane_q, lane_d;
  logic [CNT_W-1:0]            rpt_count_q, rpt_count_d;
  logic                        handshake;

  majority_voter #(
    .WIDTH(WIDTH)
  ) u_voter (
    .a    (in_a),
    .b    (in_b),
    .c    (in_c),
    .vote (vote),
    .dis_a(dis[0]),
    .dis_b(dis[1]),
    .dis_c(dis[2])
  );

  // Vote path: out holds when idle, event flags are single-cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
      err_c     <= 1'b0;
      multi_err <= 1'b0;
    end else if (in_valid) begin
      out       <= vote;
      out_valid <= 1'b1;
      err_a     <= dis[0];
      err_b     <= dis[1];
      err_c     <= dis[2];
      multi_err <= (dis[0] & dis[1]) | (dis[0] & dis[2]) | (dis[1] & dis[2]);
    end else begin
      out_valid <= 1'b0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
      err_c     <= 1'b0;
      multi_err <= 1'b0;
    end
  end

  assign rpt_valid = (state_q == REPORT);
  assign handshake = rpt_valid & rpt_ready;

  // Counter priority: clear, then acceptance of this lane's report, then increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        cnt_d[i] = '0;
      end else if (handshake && (lane_q == lane_t'(i))) begin
        cnt_d[i] = '0;
      end else if (in_valid && dis[i] && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    rpt_count_d = rpt_count_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q[0] >= ThreshCnt) begin
          lane_d      = LANE_A;
          rpt_count_d = cnt_q[0];
          state_d     = REPORT;
        end else if (cnt_q[1] >= ThreshCnt) begin
          lane_d      = LANE_B;
          rpt_count_d = cnt_q[1];
          state_d     = REPORT;
        end else if (cnt_q[2] >= ThreshCnt) begin
          lane_d      = LANE_C;
          rpt_count_d = cnt_q[2];
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (rpt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      state_q     <= IDLE;
      lane_q      <= LANE_A;
      rpt_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      lane_q      <= lane_d;
      rpt_count_q <= rpt_count_d;
    end
  end

  assign cnt_a     = cnt_q[0];
  assign cnt_b     = cnt_q[1];
  assign cnt_c     = cnt_q[2];
  assign rpt_lane  = lane_q;
  assign rpt_count = rpt_count_q;

endmodule
